mem_arbiter: RTL and testbench

//   Shares the single-port unified instruction/data Memory between two requesters:

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified Memory between instruction fetch (port 0)
// and load/store (port 1). Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter #(
    parameter int AW          = 6,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       grant;
    logic       lat_we;
    logic       last_grant;
    logic       win;
    logic       last_cycle;

    always_comb begin
        win = req1;
        if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            win = ~last_grant;
`else
            win = 1'b1;
`endif
        end
    end

`ifndef MEM_ARB_RR_EN
    // last_grant is tracked in both builds but only steers ties in round-robin mode
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // write strobe is decoded from state so an async reset removes it at once
    assign last_cycle = (state == ACCESS) && (cnt == '0);
    assign mem_we     = last_cycle && lat_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            last_grant <= 1'b1;
            mem_a      <= '0;
            mem_wd     <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant      <= win;
                        last_grant <= win;
                        lat_we     <= win ? we1 : we0;
                        mem_a      <= win ? addr1 : addr0;
                        mem_wd     <= win ? wdata1 : wdata0;
                        cnt        <= CNT_INIT;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!lat_we) begin
                            if (grant) rdata1 <= mem_rd;
                            else       rdata0 <= mem_rd;
                        end
                        ack0  <= ~grant;
                        ack1  <= grant;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (WAIT_STATES 0 and 3) with behavioural Memories,
// checked against a transaction-level reference model. Honors MEM_ARB_RR_EN.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0 [2];
    logic        we0  [2];
    logic [5:0]  addr0[2];
    logic [31:0] wdata0[2];
    logic        ack0 [2];
    logic [31:0] rdata0[2];
    logic        req1 [2];
    logic        we1  [2];
    logic [5:0]  addr1[2];
    logic [31:0] wdata1[2];
    logic        ack1 [2];
    logic [31:0] rdata1[2];
    logic        mem_we[2];
    logic [5:0]  mem_a [2];
    logic [31:0] mem_wd[2];
    logic [31:0] mem_rd[2];

    logic [31:0] mem_arr[2][16];
    logic        pl_en = 1'b0;
    int          pl_k;
    int          pl_i;
    logic [31:0] pl_v;

    // reference model state
    logic [31:0] ref_mem[2][16];
    logic [31:0] rd_m[2][2];
    bit          lg[2];

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(6), .DW(32), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .ack0(ack0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .ack1(ack1[0]), .rdata1(rdata1[0]),
        .mem_we(mem_we[0]), .mem_a(mem_a[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0])
    );

    mem_arbiter #(.AW(6), .DW(32), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .ack0(ack0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .ack1(ack1[1]), .rdata1(rdata1[1]),
        .mem_we(mem_we[1]), .mem_a(mem_a[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1])
    );

    // word-addressed Memories, combinational read, write on posedge
    always @(posedge clk) begin
        if (pl_en) mem_arr[pl_k][pl_i] <= pl_v;
        for (int k = 0; k < 2; k++)
            if (mem_we[k]) mem_arr[k][mem_a[k][5:2]] <= mem_wd[k];
    end

    always_comb begin
        for (int k = 0; k < 2; k++) mem_rd[k] = mem_arr[k][mem_a[k][5:2]];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input int k, input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_RR_EN
            return ~lg[k];
`else
            return 1'b1;
`endif
        end
        return r1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, ".ack0"},   32'(ack0[k]),   '0);
            check({tag, ".ack1"},   32'(ack1[k]),   '0);
            check({tag, ".rdata0"}, rdata0[k],      '0);
            check({tag, ".rdata1"}, rdata1[k],      '0);
            check({tag, ".mem_we"}, 32'(mem_we[k]), '0);
            check({tag, ".mem_a"},  32'(mem_a[k]),  '0);
            check({tag, ".mem_wd"}, mem_wd[k],      '0);
        end
    endtask

    task automatic model_reset();
        lg[0] = 1'b1; lg[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd_m[k][0] = '0;
            rd_m[k][1] = '0;
        end
    endtask

    // one transaction from IDLE: drives at edge+1, returns in IDLE after the ack
    task automatic xfer(input int k, input bit r0, input bit r1, input bit w0, input bit w1,
                        input logic [5:0] a0, input logic [5:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input bit drop, input string tag);
        int          ws;
        bit          win;
        bit          w;
        logic [5:0]  a;
        logic [31:0] d;
        int          wecnt;
        ws    = (k == 0) ? 0 : 3;
        wecnt = 0;
        win   = pick(k, r0, r1);
        lg[k] = win;
        w = win ? w1 : w0;
        a = win ? a1 : a0;
        d = win ? d1 : d0;
        req0[k] = r0; we0[k] = w0; addr0[k] = a0; wdata0[k] = d0;
        req1[k] = r1; we1[k] = w1; addr1[k] = a1; wdata1[k] = d1;
        for (int c = 1; c <= ws + 3; c++) begin
            @(posedge clk); #1;
            if (mem_we[k]) wecnt++;
            if (c <= ws + 2) begin
                check({tag, ".mem_a"},  32'(mem_a[k]), 32'(a));
                check({tag, ".mem_wd"}, mem_wd[k], d);
            end
            if (drop && c == 1) begin
                if (win) req1[k] = 1'b0;
                else     req0[k] = 1'b0;
            end
            if (c == ws + 2) begin
                if (w) ref_mem[k][a[5:2]] = d;
                else   rd_m[k][win] = ref_mem[k][a[5:2]];
                check({tag, ".ack0"},   32'(ack0[k]), 32'(!win));
                check({tag, ".ack1"},   32'(ack1[k]), 32'(win));
                check({tag, ".rdata0"}, rdata0[k], rd_m[k][0]);
                check({tag, ".rdata1"}, rdata1[k], rd_m[k][1]);
                check({tag, ".we_cnt"}, 32'(wecnt), 32'(w));
                req0[k] = 1'b0;
                req1[k] = 1'b0;
            end else begin
                check({tag, ".ack_off"}, 32'(ack0[k] | ack1[k]), '0);
            end
        end
    endtask

    initial begin
        bit          r0, r1, drop;
        int          k;
        bit          win;
        logic [31:0] old_word;
        for (int i = 0; i < 2; i++) begin
            req0[i] = 0; we0[i] = 0; addr0[i] = '0; wdata0[i] = '0;
            req1[i] = 0; we1[i] = 0; addr1[i] = '0; wdata1[i] = '0;
        end
        rst_n = 1'b0;
        model_reset();

        // preload both Memories while in reset
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                pl_k = m;
                pl_i = i;
                pl_v = (m == 0 && i == 1) ? 32'hac250004 : $urandom;
                ref_mem[m][i] = pl_v;
                pl_en = 1'b1;
                @(posedge clk); #1;
            end
        end
        pl_en = 1'b0;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // single read, zero wait states
        xfer(0, 1, 0, 0, 0, 6'h04, 6'h00, '0, '0, 0, "t1_read");
        check("t1_rdata0", rdata0[0], 32'hac250004);

        // write then read on port 1
        xfer(0, 0, 1, 0, 1, 6'h00, 6'h08, '0, 32'h00000005, 0, "t2_write");
        xfer(0, 0, 1, 0, 0, 6'h00, 6'h08, '0, '0, 0, "t2_read");
        check("t2_rdata1", rdata1[0], 32'h00000005);
        check("t2_rdata0", rdata0[0], 32'hac250004);

        // tie with both requests held across four grants
        req0[0] = 1; we0[0] = 0; addr0[0] = 6'h04;
        req1[0] = 1; we1[0] = 0; addr1[0] = 6'h08;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c % 3 == 2) begin
                win = pick(0, 1, 1);
                lg[0] = win;
                rd_m[0][win] = ref_mem[0][win ? 2 : 1];
                check("t3_ack0", 32'(ack0[0]), 32'(!win));
                check("t3_ack1", 32'(ack1[0]), 32'(win));
                check("t3_rdata", win ? rdata1[0] : rdata0[0], rd_m[0][win]);
            end else begin
                check("t3_ack_off", 32'(ack0[0] | ack1[0]), '0);
            end
            if (c == 12) begin
                req0[0] = 0;
                req1[0] = 0;
            end
        end

        // three wait states
        xfer(1, 1, 0, 0, 0, 6'h10, 6'h00, '0, '0, 0, "t4_ws3");

        // request dropped after grant, then no further access
        xfer(0, 1, 0, 0, 0, 6'h0c, 6'h00, '0, '0, 1, "t6_drop");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("t6_idle_ack", 32'(ack0[0] | ack1[0]), '0);
            check("t6_idle_we",  32'(mem_we[0]), '0);
        end

        // randomized traffic on both arbiters
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 1);
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            drop = ($urandom_range(0, 3) == 0);
            xfer(k, r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 6'($urandom), 6'($urandom), $urandom, $urandom, drop, "rand");
        end

        // reset in the middle of a waited write: counter at 2
        old_word = ref_mem[1][8];
        req1[1] = 1; we1[1] = 1; addr1[1] = 6'h20; wdata1[1] = ~old_word;
        @(posedge clk); #1;
        check("t5_we_c1", 32'(mem_we[1]), '0);
        @(posedge clk); #1;
        check("t5_we_c2", 32'(mem_we[1]), '0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        req1[1] = 0; we1[1] = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_mem_word", mem_arr[1][8], old_word);

        // first tie after reset
        xfer(0, 1, 1, 0, 0, 6'h04, 6'h08, '0, '0, 0, "t5_tie");

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 16; i++)
                check("final_mem", mem_arr[m][i], ref_mem[m][i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
